mem_access_unit: RTL and testbench

Multi-cycle data-memory stage between execute and writeback in the sequential 64-bit core. It accepts one load/store request at a time over a valid/ready handshake and performs a byte-addressed, little-endian access to an internal data memory. It returns a sign- or zero-extended 64-bit result that the writeback stage selects for the register-file write port, and flags misaligned accesses.

---
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit with an internal byte-addressed little-endian data memory.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to fault misaligned accesses instead of force-aligning them.
module mem_access_unit #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        resp_valid,
  output logic [63:0] rdata,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    logic [63:0]   wdata;
  } req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          req_q, req_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;

  logic [7:0]    mem [DEPTH_BYTES];

  logic [3:0]    nbytes;
  logic [AW-1:0] mask;
  logic [AW-1:0] eff_addr;
  logic          fault;
  logic          commit;
  logic          do_store;
  logic [63:0]   raw;
  logic [63:0]   ext;

  // Upper address bits only select aliases of the same memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[63:AW];

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin : access_decode
    nbytes = 4'd1 << req_q.f3[1:0];
    mask   = AW'(nbytes - 4'd1);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    eff_addr = req_q.addr;
    fault    = (|(req_q.addr & mask)) && (req_q.wr || (req_q.rd && req_q.f3 != 3'b111));
`else
    eff_addr = req_q.addr & ~mask;
    fault    = 1'b0;
`endif
    // Byte i wraps modulo the memory size through AW-bit index arithmetic.
    raw = '0;
    for (int i = 0; i < 8; i++) begin
      raw[8*i +: 8] = mem[eff_addr + AW'(i)];
    end
    ext = '0;
    case (req_q.f3)
      3'b000:  ext = {{56{raw[7]}},  raw[7:0]};
      3'b001:  ext = {{48{raw[15]}}, raw[15:0]};
      3'b010:  ext = {{32{raw[31]}}, raw[31:0]};
      3'b011:  ext = raw;
      3'b100:  ext = {56'd0, raw[7:0]};
      3'b101:  ext = {48'd0, raw[15:0]};
      3'b110:  ext = {32'd0, raw[31:0]};
      default: ext = '0;
    endcase
  end

  assign commit   = (state_q == BUSY) && (cnt_q == '0);
  assign do_store = commit && req_q.wr && !fault;

  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.rd    = mem_read;
          req_d.wr    = mem_write;
          req_d.f3    = funct3;
          req_d.addr  = addr[AW-1:0];
          req_d.wdata = wdata;
          cnt_d       = CW'(LATENCY - 1);
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          mis_d   = fault;
          // A simultaneous read+write is a store; only a clean load returns data.
          rdata_d = (req_q.rd && !req_q.wr && !fault) ? ext : '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // NOTE: the memory array has no reset branch; clearing it would need a write port per byte.
  always_ff @(posedge clk) begin
    if (do_store && !reset) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(nbytes)) mem[eff_addr + AW'(i)] <= req_q.wdata[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign rdata      = rdata_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized traffic
// against a byte-array reference model.
module tb_mem_access_unit;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        resp_valid;
  logic [63:0] rdata;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [DEPTH];

  mem_access_unit #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h required 0x%h", tag, got, exp);
    end
  endtask

  // Reference behaviour: size from funct3, byte-wise little-endian access modulo DEPTH.
  function automatic void model_op(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] wd,
                                   output logic [63:0] er, output bit em);
    int unsigned       size;
    longint unsigned   base;
    logic [63:0]       val;
    size = 1 << f3[1:0];
    base = a % DEPTH;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    em = ((a % size) != 0) && (wr || (rd && f3 != 3'b111));
`else
    em = 1'b0;
    base = base - (base % size);
`endif
    er = '0;
    if (rd && !wr && !em && f3 != 3'b111) begin
      val = '0;
      for (int i = 0; i < int'(size); i++)
        val = val | (64'(model_mem[(base + i) % DEPTH]) << (8 * i));
      if (!f3[2] && size < 8 && val[8*size-1])
        val = val | ~((64'd1 << (8 * size)) - 64'd1);
      er = val;
    end
    if (wr && !em)
      for (int i = 0; i < int'(size); i++)
        model_mem[(base + i) % DEPTH] = wd[8*i +: 8];
  endfunction

  // Issue one request from a negedge while idle; check latency, result and handshake.
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input string tag, output logic [63:0] obs);
    logic [63:0] er;
    bit          em;
    int          lat;
    bit          got;
    model_op(rd, wr, f3, a, wd, er, em);
    check({tag, "_ready_idle"}, req_ready, 1);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        got = 1'b1;
        lat = k;
        break;
      end
      check({tag, "_ready_busy"}, req_ready, 0);
    end
    obs = rdata;
    if (!got) begin
      check({tag, "_resp_timeout"}, 0, 1);
    end else begin
      check({tag, "_latency"}, lat, LAT);
      check({tag, "_rdata"}, rdata, er);
      check({tag, "_misaligned"}, misaligned, em);
      check({tag, "_ready_resp"}, req_ready, 0);
      @(posedge clk); #1;
      check({tag, "_resp_one_cycle"}, resp_valid, 0);
      check({tag, "_ready_after"}, req_ready, 1);
      check({tag, "_rdata_hold"}, rdata, er);
    end
    @(negedge clk);
  endtask

  logic [63:0] obs;
  int          last_acc;
  int          n_acc;
  bit          seen;

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'd0;
    addr      = '0;
    wdata     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_misaligned", misaligned, 0);
    @(negedge clk);
    reset = 1'b0;

    // Give every byte a known value so later loads are fully predictable.
    for (int i = 0; i < DEPTH / 8; i++)
      run_op(1'b0, 1'b1, 3'b011, 64'(i * 8), {$urandom, $urandom}, "fill", obs);

    run_op(1'b0, 1'b1, 3'b011, 64'h10, 64'h1122334455667788, "sd10", obs);
    run_op(1'b1, 1'b0, 3'b011, 64'h10, 64'h0, "ld10", obs);
    check("ld10_literal", obs, 64'h1122334455667788);

    run_op(1'b0, 1'b1, 3'b011, 64'h20, 64'h0, "sd20_clear", obs);
    run_op(1'b0, 1'b1, 3'b000, 64'h20, 64'h80, "sb20", obs);
    run_op(1'b1, 1'b0, 3'b000, 64'h20, 64'h0, "lb20", obs);
    check("lb20_literal", obs, 64'hFFFFFFFFFFFFFF80);
    run_op(1'b1, 1'b0, 3'b100, 64'h20, 64'h0, "lbu20", obs);
    check("lbu20_literal", obs, 64'h80);
    run_op(1'b1, 1'b0, 3'b010, 64'h20, 64'h0, "lw20", obs);
    check("lw20_literal", obs, 64'h80);

    run_op(1'b1, 1'b0, 3'b010, 64'h22, 64'h0, "lw22", obs);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    check("lw22_literal", obs, 64'h0);
`else
    check("lw22_literal", obs, 64'h80);
`endif
    run_op(1'b0, 1'b1, 3'b010, 64'h22, 64'hDEADBEEF, "sw22", obs);
    run_op(1'b1, 1'b0, 3'b110, 64'h20, 64'h0, "lwu20_after_sw22", obs);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    check("lwu20_literal", obs, 64'h80);
`else
    check("lwu20_literal", obs, 64'hDEADBEEF);
`endif
    run_op(1'b1, 1'b0, 3'b010, 64'h24, 64'h0, "lw24_after_sw22", obs);

    run_op(1'b0, 1'b1, 3'b011, 64'(DEPTH + 8), 64'hAA, "sd_wrap", obs);
    run_op(1'b1, 1'b0, 3'b011, 64'h8, 64'h0, "ld_wrap", obs);
    check("ld_wrap_literal", obs, 64'hAA);

    run_op(1'b1, 1'b1, 3'b011, 64'h40, 64'h0123456789ABCDEF, "rdwr40", obs);
    run_op(1'b1, 1'b0, 3'b011, 64'h40, 64'h0, "ld40", obs);
    run_op(1'b0, 1'b0, 3'b011, 64'h41, 64'h0, "noop", obs);
    run_op(1'b1, 1'b0, 3'b111, 64'h10, 64'h0, "f3_111", obs);

    // Back-to-back: req_valid held high, accepts must be spaced LAT+2 apart.
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b011;
    addr      = 64'h0;
    req_valid = 1'b1;
    last_acc  = -1;
    n_acc     = 0;
    for (int c = 0; c < 4 * (LAT + 2); c++) begin
      if (resp_valid) check("hs_ready_in_resp", req_ready, 0);
      if (req_ready) begin
        if (last_acc >= 0) check("hs_gap", c - last_acc, LAT + 2);
        last_acc = c;
        n_acc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("hs_accepts", n_acc, 4);
    seen = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      if (req_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("hs_drain", seen, 1);

    // Abort a store by asserting reset on its commit edge.
    run_op(1'b0, 1'b1, 3'b011, 64'h30, 64'h11, "sd30_preset", obs);
    mem_read  = 1'b0;
    mem_write = 1'b1;
    funct3    = 3'b011;
    addr      = 64'h30;
    wdata     = 64'h55;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", req_ready, 1);
    check("abort_rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("abort_no_resp", seen, 0);
    run_op(1'b1, 1'b0, 3'b011, 64'h30, 64'h0, "ld30_after_abort", obs);
    check("ld30_literal", obs, 64'h11);

    for (int n = 0; n < 200; n++) begin
      bit          rd, wr;
      logic [2:0]  f3;
      logic [63:0] a;
      rd = 1'($urandom_range(1, 0));
      wr = 1'($urandom_range(1, 0));
      f3 = 3'($urandom_range(7, 0));
      if (wr) f3[2] = 1'b0;
      a = {$urandom, $urandom};
      if ($urandom_range(1, 0) == 1) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      run_op(rd, wr, f3, a, {$urandom, $urandom}, "rand", obs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
